controle_pc: RTL and testbench
==============================

# controle_pc

Program-counter sequencer for the 32-bit processor datapath. Owns the PC register and drives the instruction-memory fetch handshake. Hands each fetched instruction to the decoder, then selects the next PC from sequential, branch, jump and jump-register sources. `soma_pc` feeds the jump/branch adder, whose result returns on `br_target`.

## Interface
- `RESET_PC`, 32'h0000_0000: PC loaded on reset.
- `clock`  in  1  single system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `im_req`  out  1  fetch request to instruction memory.
- `im_addr`  out  32  fetch address; equals current PC.
- `im_ack`  in  1  memory returns `im_data` this cycle.
- `im_data`  in  32  instruction word.
- `inst`  out  32  latched instruction for the decoder.
- `inst_valid`  out  1  one-cycle pulse when `inst` is newly loaded.
- `soma_pc`  out  32  PC + 4 of the current instruction.
- `exec_done`  in  1  datapath finished the current instruction.
- `stall`  in  1  hazard hold; blocks PC update.
- `br_taken`  in  1  conditional branch taken.
- `br_target`  in  32  branch target from the jump adder.
- `jump`  in  1  absolute jump (J/JAL).
- `jump_idx`  in  26  instruction index field.
- `jr`  in  1  jump register.
- `jr_target`  in  32  register value for JR.
- `erro_alin`  out  1  sticky misaligned-target flag.

## Operation
- States: IDLE, FETCH, EXEC.
- IDLE: entered only from reset. Moves to FETCH on the next edge.
- FETCH:
  - `im_req`=1 and `im_addr`=pc.
  - On an edge with `im_ack`=1: `inst`<=`im_data`, go to EXEC.
  - Without `im_ack`, remain in FETCH with `im_addr` stable.
- EXEC:
  - `inst_valid`=1 during the first EXEC cycle only.
  - On an edge with `exec_done`=1 and `stall`=0: pc<=next, go to FETCH.
  - While `stall`=1, redirect inputs are ignored and the state holds.
- Next-PC priority: `jr` > `jump` > `br_taken` > sequential.
  - jr: `jr_target`.
  - jump: {soma_pc[31:28], jump_idx, 2'b00}.
  - branch: `br_target`.
  - sequential: `soma_pc`.
- Arithmetic:
  - `soma_pc` = pc + 32'd4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000, no flag).
  - Redirects are sampled only on the EXEC update edge.
- Alignment:
  - If the selected target has bits[1:0] != 0, `erro_alin` sets and stays set until reset.
  - pc loads the target with bits[1:0] forced to 00.
- Multiple redirect inputs asserted together: the highest priority wins, with no error.

## Timing
- Reset values: pc=`RESET_PC`, state IDLE, `im_req`=0, `im_addr`=`RESET_PC`, `inst`=0, `inst_valid`=0, `erro_alin`=0, `soma_pc`=`RESET_PC`+4.
- Reset asserted mid-operation clears everything immediately and asynchronously. A pending fetch is abandoned; `im_req` falls without waiting for `im_ack`.
- Zero-wait memory (`im_ack` held 1):
  - FETCH 1 cycle, EXEC ≥1 cycle.
  - Minimum 2 cycles per instruction.
  - First `im_req` is the first cycle after reset deasserts.
- `inst_valid` rises the cycle after the acknowledging edge and lasts exactly 1 cycle.
- `im_addr` and `soma_pc` change only on the EXEC->FETCH edge.
- `exec_done` outside EXEC is ignored. `im_ack` outside FETCH is ignored.

## Configuration
- `DELAY_SLOT_EN` defined:
  - On a taken redirect, the target is saved in an internal register and pc<=soma_pc (the delay-slot instruction is fetched and executed).
  - On the delay slot's update edge, pc<=saved target.
  - Redirect inputs during the delay slot are ignored and do not set `erro_alin`.
  - Reset clears the pending-target state.
- `DELAY_SLOT_EN` undefined: redirects take effect on the same update edge, with no saved-target register.

## Test plan
- Reset, `RESET_PC`=0, `im_ack`=1, `exec_done`=1 every cycle -> `im_addr` sequence 0,4,8,C; `inst_valid` pulses every 2nd cycle.
- `im_ack` withheld 3 cycles in FETCH at pc=0x10 -> `im_req` held, `im_addr`=0x10 stable, `inst_valid` stays 0 until the cycle after ack.
- At pc=0x2000_0040, `jump`=1, `jump_idx`=26'h0000100 and `br_taken`=1 together -> next `im_addr`=0x2000_0400 (jump wins); `erro_alin`=0.
- `jr`=1, `jr_target`=0x0000_0103 -> `im_addr`=0x0000_0100, `erro_alin`=1 until reset.
- `stall`=1 for 4 cycles with `exec_done`=1 and `br_taken`=1 at pc=0x8 -> PC holds. After `stall` drops, `im_addr`=`br_target`. Assert `reset` while in FETCH -> `im_req`=0 immediately, `im_addr`=`RESET_PC`.
- With `DELAY_SLOT_EN`: branch at 0x8 to 0x40 -> `im_addr` 0xC, then 0x40. Without: `im_addr` 0x40 directly.

Source files
------------

// File: rtl/controle_pc.sv
// controle_pc: program-counter sequencer for the 32-bit datapath.
// It owns the PC register and runs the instruction-memory fetch handshake.
// Each fetched word is latched for the decoder. The next PC is chosen from
// the jr, jump, branch and sequential sources, in that order of priority.
// Optional feature: define DELAY_SLOT_EN to add one branch delay slot.
// In that build a taken redirect first executes the instruction at PC+4,
// then moves to the saved target.
module controle_pc #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_ack,
    input  logic [31:0] im_data,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic [31:0] soma_pc,
    input  logic        exec_done,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jump,
    input  logic [25:0] jump_idx,
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic        erro_alin
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] EXEC  = 2'd2;

    logic [1:0]  state_reg;
    logic [31:0] pc_reg;
    logic [31:0] inst_reg;
    logic        inst_valid_reg;
    logic        erro_alin_reg;

    logic [31:0] soma;
    logic [31:0] target_raw;
    logic [31:0] target_aligned;
    logic        redirect;
    logic        update;
    logic        set_erro;
    logic [31:0] pc_next;

`ifdef DELAY_SLOT_EN
    logic        pending_reg;
    logic [31:0] saved_target_reg;
`endif

    // PC + 4 wraps naturally at 2^32; no overflow indication is needed
    assign soma = pc_reg + 32'd4;

    // Redirect target selection: jr over jump over branch
    always_comb begin
        target_raw = soma;
        redirect   = 1'b0;
        if (jr) begin
            target_raw = jr_target;
            redirect   = 1'b1;
        end else if (jump) begin
            target_raw = {soma[31:28], jump_idx, 2'b00};
            redirect   = 1'b1;
        end else if (br_taken) begin
            target_raw = br_target;
            redirect   = 1'b1;
        end
        target_aligned = {target_raw[31:2], 2'b00};
    end

    // The PC only advances on an EXEC edge that has completion and no hazard hold
    assign update = (state_reg == EXEC) && exec_done && !stall;

    // Next-PC and misalignment detection for the update edge
    always_comb begin
        pc_next  = soma;
        set_erro = 1'b0;
`ifdef DELAY_SLOT_EN
        // During the delay slot the saved target wins and fresh redirects are dropped
        if (pending_reg) begin
            pc_next = saved_target_reg;
        end else if (redirect) begin
            pc_next  = soma;
            set_erro = (target_raw[1:0] != 2'b00);
        end
`else
        if (redirect) begin
            pc_next  = target_aligned;
            set_erro = (target_raw[1:0] != 2'b00);
        end
`endif
    end

    // Sequencer FSM: IDLE -> FETCH <-> EXEC
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            case (state_reg)
                IDLE:    state_reg <= FETCH;
                FETCH:   if (im_ack) state_reg <= EXEC;
                EXEC:    if (update) state_reg <= FETCH;
                default: state_reg <= IDLE;
            endcase
        end
    end

    // PC register is written only on the EXEC update edge
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_reg <= RESET_PC;
        end else if (update) begin
            pc_reg <= pc_next;
        end
    end

    // Instruction latch and one-cycle valid pulse for the decoder
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            inst_reg       <= 32'd0;
            inst_valid_reg <= 1'b0;
        end else begin
            inst_valid_reg <= 1'b0;
            if (state_reg == FETCH && im_ack) begin
                inst_reg       <= im_data;
                inst_valid_reg <= 1'b1;
            end
        end
    end

    // Sticky misaligned-target flag, cleared only by reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            erro_alin_reg <= 1'b0;
        end else if (update && set_erro) begin
            erro_alin_reg <= 1'b1;
        end
    end

`ifdef DELAY_SLOT_EN
    // Pending redirect target held across the delay-slot instruction
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending_reg      <= 1'b0;
            saved_target_reg <= 32'd0;
        end else if (update) begin
            if (pending_reg) begin
                pending_reg <= 1'b0;
            end else if (redirect) begin
                pending_reg      <= 1'b1;
                saved_target_reg <= target_aligned;
            end
        end
    end
`endif

    assign im_req     = (state_reg == FETCH);
    assign im_addr    = pc_reg;
    assign soma_pc    = soma;
    assign inst       = inst_reg;
    assign inst_valid = inst_valid_reg;
    assign erro_alin  = erro_alin_reg;

endmodule

// File: tb/tb_controle_pc.sv
// tb_controle_pc: directed bench for controle_pc.
// Instruction memory returns im_addr ^ 32'hDEAD_0000.
// Inputs are driven and outputs sampled on the falling edge.
module tb_controle_pc;

    logic        clk;
    logic        reset;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ack;
    logic [31:0] im_data;
    logic [31:0] inst;
    logic        inst_valid;
    logic [31:0] soma_pc;
    logic        exec_done;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jump;
    logic [25:0] jump_idx;
    logic        jr;
    logic [31:0] jr_target;
    logic        erro_alin;

    int checks   = 0;
    int failures = 0;

    controle_pc dut (
        .clock     (clk),
        .reset     (reset),
        .im_req    (im_req),
        .im_addr   (im_addr),
        .im_ack    (im_ack),
        .im_data   (im_data),
        .inst      (inst),
        .inst_valid(inst_valid),
        .soma_pc   (soma_pc),
        .exec_done (exec_done),
        .stall     (stall),
        .br_taken  (br_taken),
        .br_target (br_target),
        .jump      (jump),
        .jump_idx  (jump_idx),
        .jr        (jr),
        .jr_target (jr_target),
        .erro_alin (erro_alin)
    );

    assign im_data = im_addr ^ 32'hDEAD_0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports every check
    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end else begin
            $display("ok   %s value=%h", tag, obs);
        end
    endtask

    task automatic clear_redirects();
        jr       = 1'b0;
        jump     = 1'b0;
        br_taken = 1'b0;
    endtask

    // Called at a falling edge in EXEC with redirect inputs set up
    task automatic redirect_expect(input string tag, input logic [31:0] old_pc, input logic [31:0] target);
        @(negedge clk);
`ifdef DELAY_SLOT_EN
        check_value({tag, "_slot"}, im_addr, old_pc + 32'd4);
        clear_redirects();
        @(negedge clk);
        @(negedge clk);
        check_value({tag, "_tgt"}, im_addr, target);
`else
        check_value(tag, im_addr, target);
        clear_redirects();
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        im_ack    = 1'b1;
        exec_done = 1'b1;
        stall     = 1'b0;
        br_taken  = 1'b0;
        br_target = 32'd0;
        jump      = 1'b0;
        jump_idx  = 26'd0;
        jr        = 1'b0;
        jr_target = 32'd0;

        // Reset values
        #2;
        check_value("rst_im_req", {31'd0, im_req}, 32'd0);
        check_value("rst_im_addr", im_addr, 32'h0);
        check_value("rst_inst", inst, 32'h0);
        check_value("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        check_value("rst_erro", {31'd0, erro_alin}, 32'd0);
        check_value("rst_soma_pc", soma_pc, 32'h4);

        @(negedge clk);
        reset = 1'b0;

        // Zero-wait stream: FETCH/EXEC alternate, addresses 0,4,8,C
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check_value($sformatf("seq%0d_req", k), {31'd0, im_req}, {31'd0, (k % 2) == 0});
            check_value($sformatf("seq%0d_addr", k), im_addr, 32'(4 * (k / 2)));
            check_value($sformatf("seq%0d_valid", k), {31'd0, inst_valid}, {31'd0, (k % 2) == 1});
            if (k % 2 == 1)
                check_value($sformatf("seq%0d_inst", k), inst, 32'(4 * (k / 2)) ^ 32'hDEAD_0000);
        end

        // Withheld ack at pc=0x10
        im_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_value($sformatf("wait%0d_req", k), {31'd0, im_req}, 32'd1);
            check_value($sformatf("wait%0d_addr", k), im_addr, 32'h10);
            check_value($sformatf("wait%0d_valid", k), {31'd0, inst_valid}, 32'd0);
        end
        im_ack = 1'b1;
        @(negedge clk);
        check_value("ack_valid", {31'd0, inst_valid}, 32'd1);
        check_value("ack_inst", inst, 32'h10 ^ 32'hDEAD_0000);

        // Aligned jr to 0x2000_0040
        jr        = 1'b1;
        jr_target = 32'h2000_0040;
        redirect_expect("jr_2000_0040", 32'h10, 32'h2000_0040);
        check_value("jr_align_erro", {31'd0, erro_alin}, 32'd0);

        // Jump together with branch: jump wins
        @(negedge clk);
        jump      = 1'b1;
        jump_idx  = 26'h0000100;
        br_taken  = 1'b1;
        br_target = 32'h0000_0500;
        redirect_expect("jump_wins", 32'h2000_0040, 32'h2000_0400);
        check_value("jump_erro", {31'd0, erro_alin}, 32'd0);

        // Misaligned jr target: forced alignment, sticky error
        @(negedge clk);
        jr        = 1'b1;
        jr_target = 32'h0000_0103;
        redirect_expect("jr_misalign", 32'h2000_0400, 32'h0000_0100);
        check_value("misalign_erro", {31'd0, erro_alin}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        check_value("erro_sticky", {31'd0, erro_alin}, 32'd1);

        // Asynchronous reset while in FETCH
        check_value("pre_rst_req", {31'd0, im_req}, 32'd1);
        reset = 1'b1;
        #1;
        check_value("async_rst_req", {31'd0, im_req}, 32'd0);
        check_value("async_rst_addr", im_addr, 32'h0);
        check_value("async_rst_erro", {31'd0, erro_alin}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Advance to FETCH at pc=8 (five edges), then hold with stall in EXEC
        repeat (5) @(negedge clk);
        check_value("pre_stall_addr", im_addr, 32'h8);
        stall     = 1'b1;
        br_taken  = 1'b1;
        br_target = 32'h0000_0040;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_value($sformatf("stall%0d_addr", k), im_addr, 32'h8);
            check_value($sformatf("stall%0d_req", k), {31'd0, im_req}, 32'd0);
            check_value($sformatf("stall%0d_valid", k), {31'd0, inst_valid}, {31'd0, k == 0});
        end
        stall = 1'b0;
        redirect_expect("branch_8_to_40", 32'h8, 32'h40);

        // PC wrap: jr to 0xFFFF_FFFC, then sequential step wraps to 0
        @(negedge clk);
        jr        = 1'b1;
        jr_target = 32'hFFFF_FFFC;
        redirect_expect("jr_top", 32'h40, 32'hFFFF_FFFC);
        check_value("top_soma_wrap", soma_pc, 32'h0);
        @(negedge clk);
        @(negedge clk);
        check_value("wrap_addr", im_addr, 32'h0);
        check_value("wrap_soma", soma_pc, 32'h4);
        check_value("wrap_erro", {31'd0, erro_alin}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
